// File: rtl/rsa_cipher_serializer.sv
// rtl/rsa_cipher_serializer.sv - captures each ciphertext word on ready rise and streams it out MSB byte first
module rsa_cipher_serializer #(
    parameter int DATA_W = 256,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_rdy,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_first,
    output logic              tx_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              rdy_d;
    logic              rise;
    logic              accept;
    logic              accept_last;
    logic              load;
    logic              drop;

    // rdy_d resets low, so a level already high at reset release reads as a rise
    assign rise        = in_rdy & ~rdy_d;
    assign accept      = (state == SEND) & tx_ready;
    assign accept_last = accept & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // only the last-beat handoff can absorb a new word; anything else is an overrun
                if (accept_last) begin
                    if (rise) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rise) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_d      <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rdy_d      <= in_rdy;
            frame_done <= accept_last;
            if (load) begin
                shreg <= in_data;
                cnt   <= '0;
            end else if (accept) begin
                shreg <= shreg << BYTE_W;
                cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy     = (state == SEND);
    assign tx_valid = busy;
    assign tx_data  = busy ? shreg[DATA_W-1 -: BYTE_W] : '0;
    assign tx_first = busy & (cnt == '0);
    assign tx_last  = busy & (cnt == CNT_LAST);

endmodule

// File: tb/tb_rsa_cipher_serializer.sv
// tb/tb_rsa_cipher_serializer.sv - directed self-checking bench for rsa_cipher_serializer
module tb_rsa_cipher_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] in_data;
    logic         in_rdy;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_first;
    logic         tx_last;
    logic         busy;
    logic         frame_done;
    logic         overflow;
    logic         clr_ovf;

    int n_pass  = 0;
    int n_total = 0;

    rsa_cipher_serializer #(.DATA_W(256), .BYTE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_rdy     (in_rdy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_first   (tx_first),
        .tx_last    (tx_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    endtask

    // word whose byte k (k=0 is MSB) equals base+k
    function automatic logic [255:0] mk_word(input logic [7:0] base);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            w[255-8*k -: 8] = base + 8'(k);
        end
        return w;
    endfunction

    task automatic chk_beat(input string tag, input int k, input logic [7:0] b, input logic fd);
        logic [12:0] exp;
        exp = {1'b1, (k == 0), (k == 31), 1'b1, fd, b};
        chk($sformatf("%s_beat%0d", tag, k),
            64'({tx_valid, tx_first, tx_last, busy, frame_done, tx_data}), 64'(exp));
    endtask

    // expected byte k is base + step*k; tx_ready held high, one tick per beat
    task automatic send_beats(input string tag, input logic [7:0] base, input int step,
                              input int from, input int to, input logic fd_first);
        for (int k = from; k <= to; k++) begin
            chk_beat(tag, k, base + 8'(step * k), (k == from) ? fd_first : 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] aa;
        logic         bad;
        int           e;
        int           c;

        ones     = '1;
        aa       = {32{8'hAA}};
        reset    = 1'b0;
        in_data  = '0;
        in_rdy   = 1'b0;
        tx_ready = 1'b1;
        clr_ovf  = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            64'({tx_valid, tx_first, tx_last, busy, frame_done, overflow, tx_data}), 64'(0));
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 64'({tx_valid, busy}), 64'(0));

        // basic frame, in_rdy then left high for level-hold
        in_data = mk_word(8'h00);
        in_rdy  = 1'b1;
        tick();
        send_beats("basic", 8'h00, 1, 0, 31, 1'b0);
        chk("basic_done", 64'({tx_valid, busy, frame_done}), 64'(3'b001));
        bad = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (tx_valid || busy || frame_done) bad = 1'b1;
        end
        chk("level_hold_single_frame", 64'(bad), 64'(0));
        chk("level_hold_no_ovf", 64'(overflow), 64'(0));
        in_rdy = 1'b0;
        tick();

        // backpressure with tx_ready pattern 1,0,0,1
        in_data = mk_word(8'h40);
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        e = 0;
        c = 0;
        while (e < 32 && c < 200) begin
            chk_beat("bp", e, 8'h40 + 8'(e), 1'b0);
            tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
            if (tx_ready) e++;
            c++;
        end
        chk("bp_accepted", 64'(e), 64'(32));
        chk("bp_done", 64'({tx_valid, busy, frame_done}), 64'(3'b001));
        tx_ready = 1'b1;
        tick();

        // overrun at beat 10
        in_data = mk_word(8'h80);
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        send_beats("ovr", 8'h80, 1, 0, 9, 1'b0);
        chk_beat("ovr", 10, 8'h8A, 1'b0);
        in_data = ones;
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        chk("ovr_flag_set", 64'(overflow), 64'(1));
        send_beats("ovr", 8'h80, 1, 11, 31, 1'b0);
        chk("ovr_done", 64'({tx_valid, busy, frame_done}), 64'(3'b001));
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_valid) bad = 1'b1;
        end
        chk("ovr_no_ff_frame", 64'(bad), 64'(0));
        chk("ovr_flag_sticky", 64'(overflow), 64'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovr_cleared", 64'(overflow), 64'(0));

        // back-to-back: second rise with acceptance of beat 31
        in_data = mk_word(8'hC0);
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        send_beats("b2b_a", 8'hC0, 1, 0, 30, 1'b0);
        chk_beat("b2b_a", 31, 8'hDF, 1'b0);
        in_data = aa;
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        send_beats("b2b_b", 8'hAA, 0, 0, 31, 1'b1);
        chk("b2b_done", 64'({tx_valid, busy, frame_done}), 64'(3'b001));
        tick();
        chk("b2b_fd_single", 64'(frame_done), 64'(0));

        // reset mid-frame at beat 5, with an overflow pending
        in_data = mk_word(8'h10);
        in_rdy  = 1'b1;
        tick();
        in_rdy = 1'b0;
        send_beats("rst", 8'h10, 1, 0, 1, 1'b0);
        in_rdy = 1'b1;
        tick();
        in_rdy = 1'b0;
        chk("rst_pre_ovf", 64'(overflow), 64'(1));
        send_beats("rst", 8'h10, 1, 3, 4, 1'b0);
        chk_beat("rst", 5, 8'h15, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_async_clear",
            64'({tx_valid, tx_first, tx_last, busy, frame_done, overflow, tx_data}), 64'(0));
        in_data = mk_word(8'h60);
        in_rdy  = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_valid || busy || frame_done || overflow || tx_first || tx_last || (tx_data != 8'h00))
                bad = 1'b1;
        end
        chk("rst_held_quiet", 64'(bad), 64'(0));
        reset = 1'b1;
        tick();
        send_beats("rst_new", 8'h60, 1, 0, 31, 1'b0);
        chk("rst_new_done", 64'({tx_valid, busy, frame_done}), 64'(3'b001));
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_valid) bad = 1'b1;
        end
        chk("rst_new_single_frame", 64'(bad), 64'(0));
        in_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rsa_cipher_serializer.md
# rsa_cipher_serializer

Downstream stage of the RSA encryption core: captures each 256-bit ciphertext word when the encryptor raises its ready flag and streams it out as bytes, most-significant byte first, over a valid/ready handshake. It decouples the wide, level-style `ENCRY_DATA`/`ENCRY_RDY` result from a byte-wide transmit path such as a UART or FIFO. Overruns are flagged, never silently merged.

## Interface
- `DATA_W`, 256, ciphertext width; must be an integer multiple of `BYTE_W`.
- `BYTE_W`, 8, output beat width; `NBYTES = DATA_W/BYTE_W`, which must be at least 2.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `in_data` in DATA_W: ciphertext; connects to `ENCRY_DATA`.
- `in_rdy` in 1: ciphertext-ready level; connects to `ENCRY_RDY`.
- `tx_data` out BYTE_W: current byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts a beat.
- `tx_first` out 1: current beat is byte 0 (MSB) of a frame.
- `tx_last` out 1: current beat is byte `NBYTES-1` (LSB).
- `busy` out 1: a frame is held or being sent.
- `frame_done` out 1: one-cycle pulse after the last beat is accepted.
- `overflow` out 1: sticky; a ciphertext was dropped.
- `clr_ovf` in 1: synchronous clear of `overflow`.

## Operation
- Rising-edge detect on `in_rdy`:
  - `rdy_d` is the `in_rdy` value registered each cycle, reset to 0.
  - `rise = in_rdy & ~rdy_d`.
  - A level that is already high when reset is released counts as one rise.
- States: IDLE, SEND.
- IDLE:
  - `tx_valid=0`.
  - On `rise`: load `shreg <= in_data`, `cnt <= 0`, go to SEND.
- SEND:
  - `tx_valid=1`, `tx_data = shreg[DATA_W-1 -: BYTE_W]`.
  - `tx_first = (cnt==0)`, `tx_last = (cnt==NBYTES-1)`.
  - A beat is accepted when `tx_valid & tx_ready`. Then `shreg <= shreg << BYTE_W` and `cnt <= cnt+1`.
  - While `tx_ready=0`, `tx_data`, `tx_first` and `tx_last` hold stable.
  - On acceptance of the last beat: `frame_done` pulses next cycle and the state returns to IDLE.
- Simultaneous events in SEND:
  - `rise` coinciding with acceptance of the last beat: the new word is captured, `cnt <= 0`, state stays SEND, `frame_done` still pulses. This gives back-to-back frames with no idle cycle.
  - `rise` at any other SEND cycle: the new word is dropped, the current frame is unaffected, and `overflow <= 1`.
- `clr_ovf` clears `overflow`. If a drop occurs in the same cycle, set wins.
- `busy = (state==SEND)`.
- `cnt` width is `clog2(NBYTES)`. It never wraps past `NBYTES-1`; the last beat always exits or reloads.
- Reset mid-frame abandons the frame. No partial `frame_done` is produced.

## Timing
- Reset values: `tx_data=0`, `tx_valid=0`, `tx_first=0`, `tx_last=0`, `busy=0`, `frame_done=0`, `overflow=0`, state IDLE, `shreg=0`, `cnt=0`, `rdy_d=0`.
- All outputs are registered or decoded only from registers. There is no combinational path from `tx_ready` or `in_rdy` to any output.
- Capture latency: `in_rdy` rises before edge N; `tx_valid=1` with byte 0 is visible after edge N.
- Throughput is 1 byte per cycle with `tx_ready` held high. A frame occupies `NBYTES` (32) cycles of `tx_valid`.
- `frame_done` is high for exactly one cycle after the edge that accepts the last beat.
- `in_rdy` staying high for many cycles produces one capture only. It must drop for at least one cycle before the next word is recognised.

## Test plan
- Basic frame:
  - Stimulus: `in_data = 0x00010203…1F` (byte k = k), `in_rdy` rises and stays high, `tx_ready=1`.
  - Required: 32 beats 0x00…0x1F; `tx_first` only on 0x00; `tx_last` only on 0x1F; `frame_done` one pulse; `busy` high for exactly 32 cycles.
- Backpressure:
  - Stimulus: `tx_ready` toggles 1,0,0,1 repeatedly.
  - Required: no byte duplicated or skipped; `tx_data` stable during every stall; 32 accepted beats total.
- Overrun:
  - Stimulus: a second `in_rdy` rise with `in_data=0xFF…FF` at beat 10.
  - Required: the first frame completes intact; no 0xFF frame follows; `overflow=1`.
  - Then `clr_ovf` pulses: `overflow` returns to 0.
- Back-to-back:
  - Stimulus: second rise aligned with acceptance of beat 31, `in_data=0xAA…AA`.
  - Required: `tx_valid` never drops; the next beat is 0xAA with `tx_first=1`; `frame_done` pulses once.
- Reset mid-frame:
  - Stimulus: `reset` low at beat 5.
  - Required: all outputs return to their reset values immediately; no `frame_done`.
  - Then `in_rdy` held high while `reset` releases: one new frame starts.
- Level hold:
  - Stimulus: `in_rdy` held high for 100 cycles.
  - Required: exactly one frame and `overflow` stays 0.
